// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller in front of a single-port 1K x 16 RAM.
// Pushes become circular-buffer writes; reads are prefetched into a 4-entry output buffer.
module ram_fifo_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_wr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_out,
  output logic [ADDR_W+1:0] count,
  output logic              full,
  output logic              empty
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int OBUF_N = 4;

  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  ram_count_reg, ram_count_next;
  logic [1:0]        inflight_reg, inflight_next;
  logic [2:0]        obuf_count_reg, obuf_count_next;
  logic [1:0]        obuf_head_reg, obuf_head_next;
  logic [1:0]        obuf_tail_reg, obuf_tail_next;
  logic              last_was_read_reg, last_was_read_next;
  logic [DATA_W-1:0] obuf_reg [OBUF_N];

  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic [DATA_W-1:0] ram_in_reg, ram_in_next;
  logic              ram_wr_reg, ram_wr_next;
  logic              ram_rd_reg, ram_rd_next;
  // RAM_OUT becomes valid the cycle after RD was presented; this flag marks that cycle.
  logic              capture_reg;

  logic       rd_req;
  logic       wr_grant;
  logic       rd_grant;
  logic       pop;
  logic [3:0] pending;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr);
    if (ptr == ADDR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + ADDR_W'(1);
  endfunction

  assign pending  = 4'(obuf_count_reg) + 4'(inflight_reg);
  assign rd_req   = (ram_count_reg != '0) && (pending < 4'd4);
  assign full     = (ram_count_reg == CNT_W'(DEPTH));
  // Writes yield to a pending read unless the previous grant already went to a read.
  assign s_ready  = rst_n && !full && (!rd_req || last_was_read_reg);
  assign wr_grant = s_valid && s_ready;
  assign rd_grant = rd_req && !wr_grant;

  assign m_valid  = (obuf_count_reg != '0);
  assign pop      = m_valid && m_ready;
  assign m_data   = obuf_reg[obuf_head_reg];

  assign count    = (ADDR_W+2)'(ram_count_reg) + (ADDR_W+2)'(inflight_reg)
                  + (ADDR_W+2)'(obuf_count_reg);
  assign empty    = (count == '0);

  assign ram_addr = ram_addr_reg;
  assign ram_in   = ram_in_reg;
  assign ram_wr   = ram_wr_reg;
  assign ram_rd   = ram_rd_reg;

  always_comb begin
    wr_ptr_next        = wr_ptr_reg;
    rd_ptr_next        = rd_ptr_reg;
    ram_count_next     = ram_count_reg;
    last_was_read_next = last_was_read_reg;
    ram_addr_next      = ram_addr_reg;
    ram_in_next        = ram_in_reg;
    ram_wr_next        = 1'b0;
    ram_rd_next        = 1'b0;

    if (wr_grant) begin
      ram_addr_next      = wr_ptr_reg;
      ram_in_next        = s_data;
      ram_wr_next        = 1'b1;
      wr_ptr_next        = ptr_inc(wr_ptr_reg);
      ram_count_next     = ram_count_reg + CNT_W'(1);
      last_was_read_next = 1'b0;
    end else if (rd_grant) begin
      ram_addr_next      = rd_ptr_reg;
      ram_rd_next        = 1'b1;
      rd_ptr_next        = ptr_inc(rd_ptr_reg);
      ram_count_next     = ram_count_reg - CNT_W'(1);
      last_was_read_next = 1'b1;
    end
  end

  always_comb begin
    inflight_next   = inflight_reg + 2'(rd_grant) - 2'(capture_reg);
    obuf_count_next = obuf_count_reg + 3'(capture_reg) - 3'(pop);
    obuf_head_next  = pop ? obuf_head_reg + 2'd1 : obuf_head_reg;
    obuf_tail_next  = capture_reg ? obuf_tail_reg + 2'd1 : obuf_tail_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      ram_count_reg     <= '0;
      inflight_reg      <= '0;
      obuf_count_reg    <= '0;
      obuf_head_reg     <= '0;
      obuf_tail_reg     <= '0;
      last_was_read_reg <= 1'b0;
      ram_addr_reg      <= '0;
      ram_in_reg        <= '0;
      ram_wr_reg        <= 1'b0;
      ram_rd_reg        <= 1'b0;
      capture_reg       <= 1'b0;
    end else begin
      wr_ptr_reg        <= wr_ptr_next;
      rd_ptr_reg        <= rd_ptr_next;
      ram_count_reg     <= ram_count_next;
      inflight_reg      <= inflight_next;
      obuf_count_reg    <= obuf_count_next;
      obuf_head_reg     <= obuf_head_next;
      obuf_tail_reg     <= obuf_tail_next;
      last_was_read_reg <= last_was_read_next;
      ram_addr_reg      <= ram_addr_next;
      ram_in_reg        <= ram_in_next;
      ram_wr_reg        <= ram_wr_next;
      ram_rd_reg        <= ram_rd_next;
      capture_reg       <= ram_rd_reg;
    end
  end

  // Output buffer entries; space is guaranteed because reads are only issued when it exists.
  for (genvar gi = 0; gi < OBUF_N; gi++) begin : g_obuf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        obuf_reg[gi] <= '0;
      end else if (capture_reg && (obuf_tail_reg == 2'(gi))) begin
        obuf_reg[gi] <= ram_out;
      end
    end
  end

endmodule
